// File: rtl/srl_seq.sv
// srl_seq -- sequential right shifter (logical or arithmetic).
//
// One operand is shifted right by a variable amount, one bit position per
// clock. With SRL_SEQ_STEP4_EN defined, the shifter moves four positions per
// clock while at least four remain, then single steps. The result is the same
// in both builds; only the latency differs.
//
// Parameters
//   WIDTH    operand/result width (>= 2; >= 4 when SRL_SEQ_STEP4_EN is defined)
//   SHAMT_W  shift-amount width, legal amounts 0..WIDTH-1
//
// Ports
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   start      operation request, sampled every rising edge
//   din        operand, captured with an accepted start
//   shamt      shift amount, captured with an accepted start
//   arith      1 = sign fill, 0 = zero fill; captured with an accepted start
//   busy       high while shifting
//   done       one-cycle pulse, dout valid
//   dout       result, held from done until the next accepted start
//   dbg_state  current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
//
// Handshake: start is accepted on any rising edge where the block is in
// IDLE or DONE; a start seen while busy=1 is dropped without side effects.
// done is a one-cycle pulse per completed operation (it stays high for a
// second cycle only when a zero-amount operation is chained in the DONE
// cycle). dout only changes on the edge that enters DONE.

module srl_seq #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   din,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   dout,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   work, work_next;
  logic [SHAMT_W-1:0] rem, rem_next;
  logic               fill, fill_next;
  logic [WIDTH-1:0]   dout_r, dout_next;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      work   <= '0;
      rem    <= '0;
      fill   <= 1'b0;
      dout_r <= '0;
    end else begin
      state  <= state_next;
      work   <= work_next;
      rem    <= rem_next;
      fill   <= fill_next;
      dout_r <= dout_next;
    end
  end

  always_comb begin
    state_next = state;
    work_next  = work;
    rem_next   = rem;
    fill_next  = fill;
    dout_next  = dout_r;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          work_next  = din;
          rem_next   = shamt;
          // Sign is frozen at capture so every shifted-in bit replicates it.
          fill_next  = arith & din[WIDTH-1];
          state_next = (shamt == '0) ? DONE : SHIFT;
        end else if (state == DONE) begin
          state_next = IDLE;
        end
      end

      SHIFT: begin
`ifdef SRL_SEQ_STEP4_EN
        if (rem >= SHAMT_W'(4)) begin
          work_next = {{4{fill}}, work[WIDTH-1:4]};
          rem_next  = rem - SHAMT_W'(4);
        end else begin
          work_next = {fill, work[WIDTH-1:1]};
          rem_next  = rem - SHAMT_W'(1);
        end
`else
        work_next = {fill, work[WIDTH-1:1]};
        rem_next  = rem - SHAMT_W'(1);
`endif
        if (rem_next == '0) begin
          state_next = DONE;
        end
      end

      default: state_next = IDLE;
    endcase

    // The visible result only moves when an operation completes, so dout
    // keeps the previous answer for the whole SHIFT phase.
    if (state_next == DONE) begin
      dout_next = work_next;
    end
  end

  assign busy      = (state == SHIFT);
  assign done      = (state == DONE);
  assign dout      = dout_r;
  assign dbg_state = state;

endmodule

// File: tb/tb_srl_seq.sv
// tb_srl_seq -- self-checking bench for srl_seq.
//
// Directed operations from the test plan followed by randomized operations
// (random operand, amount, fill mode, ignored mid-shift starts and
// back-to-back chaining). Expected results come from plain >> / >>> on the
// captured operand; expected latency from the closed-form cycle count.

module tb_srl_seq;

  localparam int WIDTH   = 16;
  localparam int SHAMT_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_n;
  logic               start;
  logic [WIDTH-1:0]   din;
  logic [SHAMT_W-1:0] shamt;
  logic               arith;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   dout;
  logic [1:0]         dbg_state;

  srl_seq #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .din       (din),
    .shamt     (shamt),
    .arith     (arith),
    .busy      (busy),
    .done      (done),
    .dout      (dout),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] prev_res;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d,
                                                 input logic [SHAMT_W-1:0] s,
                                                 input logic a);
    logic signed [WIDTH-1:0] sd;
    sd = d;
    if (a) return sd >>> s;
    return d >> s;
  endfunction

  function automatic int ref_lat(input logic [SHAMT_W-1:0] s);
    int n;
    n = int'(s);
`ifdef SRL_SEQ_STEP4_EN
    return 1 + n / 4 + n % 4;
`else
    return 1 + n;
`endif
  endfunction

  // ---------------- driver ----------------
  // Called at a falling edge. Issues one operation and checks every cycle up
  // to and including the done cycle. With chain=1 it returns in the done
  // cycle so the next call starts back-to-back; otherwise it also checks
  // one idle cycle.
  task automatic run_op(input logic [WIDTH-1:0] d, input logic [SHAMT_W-1:0] s,
                        input logic a, input bit poke, input bit chain);
    int lat;
    logic [WIDTH-1:0] res;
    lat = ref_lat(s);
    exp_q.push_back(ref_shift(d, s, a));
    start = 1'b1;
    din   = d;
    shamt = s;
    arith = a;
    @(posedge clk);
    @(negedge clk);
    for (int k = 1; k <= lat; k++) begin
      start = 1'b0;
      din   = WIDTH'($urandom);
      shamt = SHAMT_W'($urandom);
      arith = 1'($urandom);
      check("busy", 32'(busy), 32'(k < lat));
      check("done", 32'(done), 32'(k == lat));
      if (k < lat) begin
        check("dout_hold", 32'(dout), 32'(prev_res));
      end else begin
        res = exp_q.pop_front();
        check("dout", 32'(dout), 32'(res));
        prev_res = res;
      end
      if (poke && k == 1 && lat >= 2) begin
        start = 1'b1;
        din   = 16'h1234;
        shamt = '0;
        arith = 1'b1;
      end
      if (k < lat) @(negedge clk);
    end
    if (!chain) begin
      @(negedge clk);
      check("idle_done", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_dout", 32'(dout), 32'(prev_res));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    din      = '0;
    shamt    = '0;
    arith    = 1'b0;
    prev_res = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    run_op(16'h8000, 4'd3, 1'b0, 1'b0, 1'b0);   // logical -> 0x1000
    run_op(16'h8000, 4'd3, 1'b1, 1'b0, 1'b1);   // arithmetic -> 0xF000, chained
    run_op(16'h7FF0, 4'd4, 1'b1, 1'b0, 1'b0);   // -> 0x07FF
    run_op(16'hA5A5, 4'd0, 1'b0, 1'b0, 1'b0);   // zero amount
    run_op(16'h8000, 4'd15, 1'b1, 1'b0, 1'b0);  // max amount -> 0xFFFF
    run_op(16'hF00F, 4'd6, 1'b0, 1'b1, 1'b0);   // ignored start mid-shift
    run_op(16'h1357, 4'd5, 1'b1, 1'b0, 1'b1);   // back-to-back
    run_op(16'h2468, 4'd2, 1'b0, 1'b0, 1'b1);
    run_op(16'hC3C3, 4'd0, 1'b1, 1'b0, 1'b0);   // chained zero: done twice
    run_op(16'h8000, 4'd15, 1'b0, 1'b0, 1'b0);  // -> 0x0001
    run_op(16'h8000, 4'd8, 1'b0, 1'b0, 1'b0);   // -> 0x0080

    // Reset during SHIFT; the start in the reset cycle must be ignored.
    start = 1'b1; din = 16'hBEEF; shamt = 4'd10; arith = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    start = 1'b1; din = 16'h5555; shamt = 4'd0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_dout", 32'(dout), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    reset_n = 1'b1;
    start   = 1'b0;
    prev_res = '0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      check("post_rst_no_done", 32'(done), 32'd0);
      check("post_rst_dout", 32'(dout), 32'd0);
    end
    run_op(16'h9001, 4'd7, 1'b1, 1'b0, 1'b0);

    // Randomized operations.
    for (int i = 0; i < 60; i++) begin
      run_op(WIDTH'($urandom), SHAMT_W'($urandom_range(0, WIDTH - 1)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
             (i != 59) && ($urandom_range(0, 2) == 0));
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/srl_seq.md
# srl_seq

Sequential right shifter: the multi-cycle complement of the constant left-shift block in the datapath catalog. It accepts an operand, a variable shift amount and a logical/arithmetic select through a start/done handshake. It shifts one bit position per clock, or up to four when configured, and holds the result until the next operation. It serves the CPU datapath's SRL/SRA instructions and any multicycle unit that needs a right shift but cannot afford a barrel shifter.

## Interface
- WIDTH, 16, operand and result width (≥ 2)
- SHAMT_W, $clog2(WIDTH), shift-amount width; legal amounts 0..WIDTH-1
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- start  in  1  request; sampled every rising edge
- din  in  WIDTH  operand, captured with an accepted start
- shamt  in  SHAMT_W  shift amount, captured with an accepted start
- arith  in  1  1 = arithmetic (sign-fill), 0 = logical (zero-fill); captured with an accepted start
- busy  out  1  high while in SHIFT
- done  out  1  one-cycle pulse; dout valid
- dout  out  WIDTH  result; held stable from done until the next accepted start

## Operation
- States: IDLE, SHIFT, DONE.
- Accepted start:
  - start=1 is accepted in IDLE or DONE.
  - On acceptance, load the working register ← din, the remaining count ← shamt, and the fill bit ← arith & din[WIDTH-1].
  - start while in SHIFT is ignored. Captured operands are unaffected and no error is flagged.
- Transitions on an accepted start:
  - shamt = 0 → DONE.
  - shamt ≠ 0 → SHIFT.
- SHIFT, each cycle:
  - Working register ← {fill, reg[WIDTH-1:1]}; remaining ← remaining − 1.
  - When remaining reaches 0, go to DONE.
- DONE:
  - done = 1 and dout = final working register.
  - Next state: IDLE, or a new operation if start=1 in this cycle.
- dout tracks the working register only in DONE/IDLE. During SHIFT it holds the previous result.
- Arithmetic fill uses the captured sign, so the sign bit is replicated for every shifted position.
- Reset values: state IDLE, busy 0, done 0, dout 0, working register 0, remaining 0.

## Timing
- Start accepted at edge N:
  - shamt = 0: done at cycle N+1.
  - Otherwise: busy during cycles N+1..N+shamt, and done at cycle N+1+shamt.
- Throughput: a start in the DONE cycle begins the next operation with no idle gap. done drops for at least one cycle unless the new shamt is 0, in which case done stays high for a second consecutive cycle with the new result.
- reset_n=0 at any edge, including mid-SHIFT:
  - All state returns to reset values at that edge. The partial result is discarded and no done is issued.
  - start in the same cycle as reset_n=0 is ignored.
- Inputs other than start are don't-care outside the accepting edge.

## Configuration
- Macro: SRL_SEQ_STEP4_EN.
- Defined:
  - In SHIFT, shift by 4 (fill 4 copies) and subtract 4 while remaining ≥ 4; otherwise shift by 1.
  - Latency = 1 + floor(shamt/4) + (shamt mod 4) cycles to done.
- Undefined: one bit per cycle, latency 1 + shamt.
- Results are bit-identical in both builds; only latency differs.

## Test plan
- Logical shift, default build: din=0x8000, shamt=3, arith=0, start at N → busy N+1..N+3, done at N+4, dout=0x1000.
- Arithmetic shift: din=0x8000, shamt=3, arith=1 → done at N+4, dout=0xF000. Then din=0x7FF0, shamt=4, arith=1 → dout=0x07FF.
- Zero and maximum amounts:
  - shamt=0, din=0xA5A5 → done at N+1, dout=0xA5A5, busy never high.
  - shamt=15, din=0x8000, arith=1 → dout=0xFFFF at N+16.
- Ignored and back-to-back starts:
  - start pulsed mid-SHIFT with din=0x1234 → ignored; the original result is unchanged.
  - start held high in the DONE cycle → the second operation completes with the correct result and latency.
- Reset mid-operation: reset_n=0 at N+2 of a shamt=10 operation → busy=0, done=0, dout=0 after that edge. No done follows. A fresh start then works normally.
- With SRL_SEQ_STEP4_EN: din=0x8000, shamt=15, arith=0 → done at N+7 (3×4 + 3×1 steps), dout=0x0001. shamt=8 → done at N+3.
